program_sequencer: RTL and testbench
====================================

# program_sequencer

Host-side controller that drives the processor core's `req`/`done` start-and-completion handshake. On a `start` pulse it launches `NUM_PROGS` programs back-to-back on the core and measures each program's run length in clock cycles. It flags a timeout if any program fails to finish. It sits beside `top_level` and replaces the hand-written bench stimulus in system runs and regressions.

## Interface
- `NUM_PROGS`, default 3: number of programs launched per sequence; minimum 1.
- `CNT_W`, default 32: width of the cycle counter and result.
- `TIMEOUT`, default 100000: maximum RUN cycles per program before abort; must be less than 2^CNT_W.
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low. 0 resets the block immediately.
- `start`, input, 1: sampled only in IDLE and FIN; a 1 begins a sequence.
- `done`, input, 1: completion level from the core.
- `req`, output, 1: one-cycle start pulse to the core.
- `prog_sel`, output, `$clog2(NUM_PROGS)` (minimum 1): index of the current program; held stable from REQ through GAP.
- `busy`, output, 1: high in REQ, RUN and GAP.
- `result_valid`, output, 1: one-cycle pulse when a program completes.
- `result_cycles`, output, `CNT_W`: run length of the last completed program; holds its value between pulses.
- `all_done`, output, 1: high in FIN.
- `timeout_err`, output, 1: sticky; set on abort, cleared by the next accepted `start`.

## Operation
- State machine states:
  - IDLE: waits for `start`.
  - REQ: drives `req`=1 for exactly one cycle.
  - RUN: counts cycles while waiting for `done`.
  - GAP: one cycle with `req`=0; records the result.
  - FIN: sequence complete.
- IDLE to REQ when `start`=1. Entering REQ sets `prog_sel`=0 and clears `timeout_err`.
- REQ to RUN unconditionally. `done` is ignored in the REQ cycle, which masks the stale `done` from the previous program; the core clears `done` on `req`.
- RUN behaviour:
  - The counter is 0 on entry and increments every RUN cycle.
  - If `done`=1 in a RUN cycle: go to GAP, with `result_cycles` = count+1 (RUN cycles including the one where `done` is sampled high).
  - If count+1 reaches `TIMEOUT` and `done`=0: set `timeout_err`, load `result_cycles`=`TIMEOUT`, no `result_valid`, go to FIN.
  - If `done`=1 and the timeout condition occur in the same cycle, `done` wins: normal completion.
- GAP:
  - `result_valid`=1 in this cycle.
  - If `prog_sel` = `NUM_PROGS`-1, go to FIN.
  - Otherwise increment `prog_sel` and go to REQ.
- FIN: `all_done`=1. A new `start` goes to REQ, clearing `all_done` and restarting at program 0.
- `start` in REQ, RUN or GAP is ignored; it is not queued.
- Counter arithmetic is unsigned `CNT_W`-bit. It never wraps, because `TIMEOUT` < 2^CNT_W.

## Timing
- Reset values: state IDLE; `req`=0, `prog_sel`=0, `busy`=0, `result_valid`=0, `result_cycles`=0, `all_done`=0, `timeout_err`=0, counter=0.
- All outputs are registered; none depends combinationally on inputs.
- Reset asserted in any state forces the reset values asynchronously. After reset release the block waits in IDLE. The core is reset separately, so no abort handshake is required.
- Cycle sequence, with `start` sampled high at edge 0:
  - Edge 1: REQ, `req`=1.
  - Edge 2: RUN.
  - If `done` is sampled high at the k-th RUN edge, GAP follows with `result_valid`=1 and `result_cycles`=k.
  - The next REQ follows one cycle later.
- Per-program overhead is 2 cycles (REQ + GAP) plus the run length.
- `done` held high across GAP and REQ is harmless because it is ignored until RUN.

## Structure
- Shared package `seq_pkg` holds:
  - `seq_state_t` enum {IDLE, REQ, RUN, GAP, FIN}.
  - Default constants `SEQ_NUM_PROGS` and `SEQ_TIMEOUT`.
- Sub-module `cycle_counter`: `CNT_W`-bit counter with synchronous clear and enable, asynchronous active-low reset, and a compare output for `TIMEOUT`-1.
- The FSM and output registers live in `program_sequencer`.

## Test plan
- Normal three-program run:
  - Stimulus: `NUM_PROGS`=3; bench core raises `done` 5, 9 and 2 RUN cycles after each `req`.
  - Response: `result_valid` pulses with `result_cycles` 5, 9, 2; `prog_sel` goes 0, 1, 2; `all_done` follows the third GAP; `timeout_err`=0.
- Stale and immediate done:
  - Stimulus: `done` held high through REQ, then stays high in the first RUN cycle.
  - Response: `req` is still a single pulse, and `result_cycles`=1 for that program.
- Timeout:
  - Stimulus: `TIMEOUT`=16; `done` never asserted on program 1.
  - Response: FIN after 16 RUN cycles with `timeout_err`=1 and `result_cycles`=16; no `result_valid` for program 1; program 2 is never requested.
- Reset mid-run:
  - Stimulus: `reset`=0 during RUN of program 1, between clock edges.
  - Response: all outputs go to reset values immediately, without waiting for an edge; after release the block stays in IDLE until `start`.
- `start` while busy, and restart:
  - Stimulus: pulse `start` in RUN, then again in FIN.
  - Response: the first pulse has no effect; the second clears `all_done` and `timeout_err` and reissues `req` with `prog_sel`=0 one cycle later.
- Simultaneous done and timeout:
  - Stimulus: `TIMEOUT`=8; `done` rises in the 8th RUN cycle.
  - Response: normal completion with `result_valid`=1 and `result_cycles`=8; `timeout_err`=0.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
// Shared types and defaults for the program sequencer: FSM state encoding,
// default sequence length / timeout, and the program-select width helper.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RUN  = 3'd2,
    GAP  = 3'd3,
    FIN  = 3'd4
  } seq_state_t;

  localparam int SEQ_NUM_PROGS = 3;
  localparam int SEQ_TIMEOUT   = 100000;

  // A single program still needs a 1-bit select so the port never collapses.
  function automatic int sel_width(input int num_progs);
    return (num_progs > 1) ? $clog2(num_progs) : 1;
  endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Host/core bundle for the program sequencer: start/done inputs, the req pulse,
// per-program results, sequence status and a debug view of the FSM state.
interface program_sequencer_if #(
  parameter int NUM_PROGS = seq_pkg::SEQ_NUM_PROGS,
  parameter int CNT_W     = 32
);
  import seq_pkg::*;

  localparam int SEL_W = sel_width(NUM_PROGS);

  // req is a one-cycle launch pulse; the core answers by raising done as a level
  // and clears it when it sees the next req. done is only honoured in RUN, so a
  // stale level left over from the previous program is harmless.
  logic             start;
  logic             done;
  logic             req;
  logic [SEL_W-1:0] prog_sel;
  logic             busy;
  logic             result_valid;
  logic [CNT_W-1:0] result_cycles;
  logic             all_done;
  logic             timeout_err;
  seq_state_t       state;

  modport master (
    input  start, done,
    output req, prog_sel, busy, result_valid, result_cycles, all_done,
           timeout_err, state
  );

  modport slave (
    output start, done,
    input  req, prog_sel, busy, result_valid, result_cycles, all_done,
           timeout_err, state
  );

endinterface

// File: rtl/program_sequencer_counter.sv
// Run-length counter: synchronous clear and enable, asynchronous active-low
// reset, and a flag raised when the count sits one below the timeout.
module cycle_counter
  import seq_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = SEQ_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             at_limit_o
);

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + CNT_ONE;
    end
  end

  assign count_o    = count_q;
  assign at_limit_o = (count_q == LIMIT);

endmodule

// File: rtl/program_sequencer.sv
// Launches NUM_PROGS programs back-to-back on the core, measures each run
// length in cycles and aborts the sequence if a program exceeds TIMEOUT.
module program_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_PROGS = SEQ_NUM_PROGS,
  parameter int CNT_W     = 32,
  parameter int TIMEOUT   = SEQ_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  program_sequencer_if.master bus
);

  localparam int               SEL_W     = sel_width(NUM_PROGS);
  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_PROGS - 1);
  localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  seq_state_t       state_q, state_d;
  logic [SEL_W-1:0] prog_sel_q, prog_sel_d;
  logic [CNT_W-1:0] result_cycles_q, result_cycles_d;
  logic             timeout_err_q, timeout_err_d;
  logic             req_q, busy_q, result_valid_q, all_done_q;

  logic [CNT_W-1:0] count;
  logic             at_limit;

  // Counter is held at zero outside RUN so every program starts counting from 0.
  cycle_counter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (state_q != RUN),
    .en_i       (state_q == RUN),
    .count_o    (count),
    .at_limit_o (at_limit)
  );

  always_comb begin
    state_d         = state_q;
    prog_sel_d      = prog_sel_q;
    result_cycles_d = result_cycles_q;
    timeout_err_d   = timeout_err_q;
    unique case (state_q)
      IDLE, FIN: begin
        if (bus.start) begin
          state_d       = REQ;
          prog_sel_d    = '0;
          timeout_err_d = 1'b0;
        end
      end
      REQ: state_d = RUN;
      RUN: begin
        // done takes priority over the timeout when both land on the same cycle.
        if (bus.done) begin
          state_d         = GAP;
          result_cycles_d = count + CNT_ONE;
        end else if (at_limit) begin
          state_d         = FIN;
          timeout_err_d   = 1'b1;
          result_cycles_d = TIMEOUT_C;
        end
      end
      GAP: begin
        if (prog_sel_q == LAST_SEL) begin
          state_d = FIN;
        end else begin
          prog_sel_d = prog_sel_q + SEL_ONE;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are flopped from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      prog_sel_q      <= '0;
      result_cycles_q <= '0;
      timeout_err_q   <= 1'b0;
      req_q           <= 1'b0;
      busy_q          <= 1'b0;
      result_valid_q  <= 1'b0;
      all_done_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      prog_sel_q      <= prog_sel_d;
      result_cycles_q <= result_cycles_d;
      timeout_err_q   <= timeout_err_d;
      req_q           <= (state_d == REQ);
      busy_q          <= (state_d inside {REQ, RUN, GAP});
      result_valid_q  <= (state_d == GAP);
      all_done_q      <= (state_d == FIN);
    end
  end

  assign bus.req           = req_q;
  assign bus.prog_sel      = prog_sel_q;
  assign bus.busy          = busy_q;
  assign bus.result_valid  = result_valid_q;
  assign bus.result_cycles = result_cycles_q;
  assign bus.all_done      = all_done_q;
  assign bus.timeout_err   = timeout_err_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Randomized bench for program_sequencer: a core model answers req with done
// after a planned latency, and a monitor scores results against a reference model.
module tb_program_sequencer;
  import seq_pkg::*;

  localparam int NP = 3;
  localparam int CW = 16;
  localparam int TO = 16;
  localparam int EW = 2 + 8 + 8 + CW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  program_sequencer_if #(.NUM_PROGS(NP), .CNT_W(CW)) bus ();

  program_sequencer #(
    .NUM_PROGS (NP),
    .CNT_W     (CW),
    .TIMEOUT   (TO)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  // Entry: {is_fin, timeout, prog_sel[7:0], nreq[7:0], cycles[CW-1:0]}
  logic [EW-1:0] exp_q[$];
  int            lat_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  bit            core_stale = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- core model ----------------
  // done rises at the d-th RUN cycle after req; latency 0 means never.
  int core_cnt = 0;
  int core_d   = 0;
  bit core_act = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.done = 1'b0;
      core_act = 1'b0;
    end else if (bus.req) begin
      core_d = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
      if (!(core_stale && core_d == 1)) bus.done = 1'b0;
      core_cnt = 0;
      core_act = (core_d != 0);
    end else if (core_act) begin
      core_cnt++;
      if (core_cnt == core_d) begin
        bus.done = 1'b1;
        core_act = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  bit            ad_prev  = 1'b0;
  bit            req_prev = 1'b0;
  int            req_cnt  = 0;
  logic [EW-1:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      ad_prev  = 1'b0;
      req_prev = 1'b0;
      req_cnt  = 0;
    end else begin
      if (bus.req) begin
        check("req_single_pulse", req_prev, 0);
        req_cnt++;
      end
      if (bus.result_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got cycles %0d sel %0d, expected none",
                   bus.result_cycles, bus.prog_sel);
        end else begin
          e = exp_q.pop_front();
          check("result_kind", 0, e[EW-1]);
          check("result_cycles", bus.result_cycles, e[CW-1:0]);
          check("result_prog_sel", bus.prog_sel, e[CW+15:CW+8]);
          check("result_busy", bus.busy, 1);
        end
      end
      if (bus.all_done && !ad_prev) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_fin: got all_done, expected none");
        end else begin
          e = exp_q.pop_front();
          check("fin_kind", 1, e[EW-1]);
          check("fin_timeout_err", bus.timeout_err, e[EW-2]);
          check("fin_prog_sel", bus.prog_sel, e[CW+15:CW+8]);
          check("fin_result_cycles", bus.result_cycles, e[CW-1:0]);
          check("fin_req_count", req_cnt, e[CW+7:CW]);
          check("fin_busy", bus.busy, 0);
        end
        req_cnt = 0;
      end
      req_prev = bus.req;
      ad_prev  = bus.all_done;
    end
  end

  // ---------------- reference model ----------------
  // Programs run in order; the first one whose done never arrives within TO
  // cycles aborts the sequence and nothing after it is launched.
  task automatic model_seq(input int d0, input int d1, input int d2);
    int d[NP];
    int nreq = 0;
    int last = 0;
    int sel  = 0;
    bit to   = 1'b0;
    d = '{d0, d1, d2};
    lat_q.delete();
    for (int i = 0; i < NP; i++) begin
      sel = i;
      nreq++;
      lat_q.push_back(d[i]);
      if (d[i] != 0 && d[i] <= TO) begin
        exp_q.push_back({1'b0, 1'b0, 8'(i), 8'd0, CW'(d[i])});
        last = d[i];
      end else begin
        to = 1'b1;
        break;
      end
    end
    exp_q.push_back({1'b1, to, 8'(sel), 8'(nreq), CW'(to ? TO : last)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_seq(input int d0, input int d1, input int d2,
                         input bit stale, input bit busy_start);
    int c = 0;
    model_seq(d0, d1, d2);
    core_stale = stale;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_req", bus.req, 1);
    check("start_prog_sel", bus.prog_sel, 0);
    check("start_all_done_clr", bus.all_done, 0);
    check("start_timeout_clr", bus.timeout_err, 0);
    if (busy_start) begin
      @(negedge clk);
      check("busy_start_in_run", bus.state, RUN);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    while (!bus.all_done && c < 600) begin
      @(negedge clk);
      c++;
    end
    if (!bus.all_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL seq_wait: got no all_done after %0d cycles, expected FIN", c);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"}, bus.req, 0);
    check({tag, "_prog_sel"}, bus.prog_sel, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_result_valid"}, bus.result_valid, 0);
    check({tag, "_result_cycles"}, bus.result_cycles, 0);
    check({tag, "_all_done"}, bus.all_done, 0);
    check({tag, "_timeout_err"}, bus.timeout_err, 0);
    check({tag, "_state"}, bus.state, IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start = 1'b0;
    bus.done  = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_release", bus.state, IDLE);

    run_seq(5, 9, 2, 1'b0, 1'b0);     // normal three-program run
    run_seq(3, 1, 4, 1'b1, 1'b0);     // stale done held into an immediate done
    run_seq(6, 0, 7, 1'b0, 1'b0);     // timeout on the second program
    run_seq(4, 5, 6, 1'b0, 1'b0);     // restart from a timed-out FIN
    run_seq(TO, 4, TO, 1'b0, 1'b0);   // done on the timeout cycle wins
    run_seq(15, TO + 1, 3, 1'b0, 1'b0);
    run_seq(7, 3, 5, 1'b0, 1'b1);     // start pulsed while busy

    // Reset asserted between edges during RUN of the first program.
    lat_q.delete();
    lat_q.push_back(12);
    core_stale = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("midrun_state", bus.state, RUN);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_vals("async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lat_q.delete();
    repeat (4) begin
      @(negedge clk);
      check("post_reset_idle", bus.state, IDLE);
      check("post_reset_busy", bus.busy, 0);
    end

    for (int s = 0; s < 25; s++) begin
      int d[NP];
      for (int i = 0; i < NP; i++)
        d[i] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO + 4));
      run_seq(d[0], d[1], d[2], 1'b0, 1'(s % 5 == 0));
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
